// File: rtl/intt_sdf_stage.sv
// Radix-2 single-path delay-feedback stage for the inverse NTT.
// Gentleman-Sande butterfly over a streamed block of 2*HALF coefficients:
// sums leave directly; twiddled differences wait in the delay line and are
// emitted while the next block's first half fills it (or during a drain).
// Optional build macro: INTT_HALF_SCALE_EN multiplies every output by 2^-1 mod q.
module intt_sdf_stage #(
    parameter int W         = 32,
    parameter int MODULUS   = 7681,
    parameter int HALF      = 4,
    parameter int RADIX     = 8,
    parameter int TW_STRIDE = 1,
    parameter logic [RADIX/2-1:0][W-1:0] INV_TWIDDLE_ARRAY =
        '{32'd6468, 32'd3383, 32'd1925, 32'd1}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         busy
);

    localparam int CW  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int TWN = RADIX / 2;
    localparam int TWW = (TWN > 1) ? $clog2(TWN) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(HALF - 1);
    localparam logic [W:0]       Q_EXT    = (W+1)'(MODULUS);
    localparam logic [2*W-1:0]   Q_WIDE   = (2*W)'(MODULUS);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_BFLY  = 2'd1,
        ST_FEED  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Modular add of two reduced operands.
    function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q_EXT) begin
            s = s - Q_EXT;
        end else begin
            s = s;
        end
        return W'(s);
    endfunction

    // Modular subtract; the W+1-bit wrap plus q yields the reduced value.
    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b) begin
            d = d + Q_EXT;
        end else begin
            d = d;
        end
        return W'(d);
    endfunction

    // Full-width product reduced modulo q.
    function automatic logic [W-1:0] mul_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return W'(p % Q_WIDE);
    endfunction

    // Multiply by 2^-1 mod q: odd values are made even by adding the odd q.
    function automatic logic [W-1:0] half_mod(input logic [W-1:0] v);
        logic [W:0] t;
        if (v[0]) begin
            t = {1'b0, v} + Q_EXT;
        end else begin
            t = {1'b0, v};
        end
        return W'(t >> 1);
    endfunction

    // Output scaling applied just before the output register.
    function automatic logic [W-1:0] out_scale(input logic [W-1:0] v);
`ifdef INTT_HALF_SCALE_EN
        return half_mod(v);
`else
        return v;
`endif
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [W-1:0]    dl_q [HALF];

    logic            beat_s;
    logic            shift_s;
    logic [W-1:0]    push_s;
    logic [W-1:0]    tail_s;
    logic [W-1:0]    sum_s;
    logic [W-1:0]    diff_s;
    logic [W-1:0]    diff_tw_s;
    logic [W-1:0]    tw_s;
    logic [31:0]     tw_idx_s;

    assign in_ready = (state_q != ST_DRAIN);
    assign beat_s   = in_valid & in_ready;
    assign tail_s   = dl_q[HALF-1];

    // Butterfly datapath: a is the oldest delay-line entry, b the live input.
    always_comb begin
        tw_idx_s  = (32'(cnt_q) * 32'(TW_STRIDE)) % 32'(TWN);
        tw_s      = INV_TWIDDLE_ARRAY[tw_idx_s[TWW-1:0]];
        sum_s     = add_mod(tail_s, in_data);
        diff_s    = sub_mod(tail_s, in_data);
        diff_tw_s = mul_mod(diff_s, tw_s);
    end

    // Next-state, delay-line control and output-register inputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_s     = 1'b0;
        push_s      = '0;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        case (state_q)
            ST_FILL: begin
                if (beat_s) begin
                    shift_s = 1'b1;
                    push_s  = in_data;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_BFLY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    shift_s = 1'b0;
                end
            end
            ST_BFLY: begin
                if (beat_s) begin
                    shift_s     = 1'b1;
                    push_s      = diff_tw_s;
                    out_valid_d = 1'b1;
                    out_data_d  = out_scale(sum_s);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_FEED;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    shift_s = 1'b0;
                end
            end
            ST_FEED: begin
                if (beat_s) begin
                    shift_s     = 1'b1;
                    push_s      = in_data;
                    out_valid_d = 1'b1;
                    out_data_d  = out_scale(tail_s);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_BFLY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if ((cnt_q == '0) && flush) begin
                    state_d = ST_DRAIN;
                end else begin
                    shift_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                shift_s     = 1'b1;
                push_s      = '0;
                out_valid_d = 1'b1;
                out_data_d  = out_scale(tail_s);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FILL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_FILL;
                cnt_d   = '0;
            end
        endcase
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Delay line: shifts only on beats and drain cycles; contents need no reset.
    always_ff @(posedge clk) begin
        if (shift_s) begin
            dl_q[0] <= push_s;
            for (int i = 1; i < HALF; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != ST_FILL) || (cnt_q != '0);

endmodule

// File: tb/tb_intt_sdf_stage.sv
// Directed bench for intt_sdf_stage (HALF=4, q=7681); expectations are
// hand-computed and switch with INTT_HALF_SCALE_EN.
module tb_intt_sdf_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_data;
    logic        busy;

    int checks;
    int errors;
    logic [31:0] held;

`ifdef INTT_HALF_SCALE_EN
    localparam logic [31:0] EXP_SUM  [4] = '{32'd3, 32'd4, 32'd5, 32'd6};
    localparam logic [31:0] EXP_DIFF [4] = '{32'd7679, 32'd3831, 32'd915, 32'd2426};
    localparam logic [31:0] EXP_BIG  = 32'd7680;
`else
    localparam logic [31:0] EXP_SUM  [4] = '{32'd6, 32'd8, 32'd10, 32'd12};
    localparam logic [31:0] EXP_DIFF [4] = '{32'd7677, 32'd7662, 32'd1830, 32'd4852};
    localparam logic [31:0] EXP_BIG  = 32'd7679;
`endif

    intt_sdf_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle with the given inputs; outputs are settled afterwards.
    task automatic step(input logic v, input logic [31:0] d, input logic f);
        in_valid = v;
        in_data  = d;
        flush    = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] d);
        check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        if (v) begin
            check(tag, out_data, d);
            held = d;
        end else begin
            check({tag, "_hold"}, out_data, held);
        end
    endtask

    // Idle cycle with flush at the FEED boundary, then the four drain cycles.
    task automatic flush_drain(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3);
        step(1'b0, 32'd0, 1'b1);
        expect_out({tag, "_flush"}, 1'b0, 32'd0);
        check({tag, "_drain_ready"}, {31'd0, in_ready}, 32'd0);
        step(1'b0, 32'd0, 1'b0);
        expect_out({tag, "_z0"}, 1'b1, d0);
        step(1'b1, 32'd99, 1'b0);   // in_ready is low: this must be ignored
        expect_out({tag, "_z1"}, 1'b1, d1);
        step(1'b0, 32'd0, 1'b0);
        expect_out({tag, "_z2"}, 1'b1, d2);
        step(1'b0, 32'd0, 1'b0);
        expect_out({tag, "_z3"}, 1'b1, d3);
        check({tag, "_end_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        held     = 32'd0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'd0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data",  out_data, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Test 1: reset in the middle of BFLY.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'(i + 11), 1'b0);
        end
        check("t1_busy_mid", {31'd0, busy}, 32'd1);
        check("t1_valid_mid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #2;
        check("t1_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t1_rst_ready", {31'd0, in_ready}, 32'd1);
        check("t1_rst_busy",  {31'd0, busy}, 32'd0);
        check("t1_rst_data",  out_data, 32'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        held = 32'd0;

        // Test 2: clean block 1..8 back to back, then flush and drain.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'(i + 1), 1'b0);
            if (i < 4) expect_out("t2_fill", 1'b0, 32'd0);
            else       expect_out("t2_sum", 1'b1, EXP_SUM[i-4]);
        end
        flush_drain("t2", EXP_DIFF[0], EXP_DIFF[1], EXP_DIFF[2], EXP_DIFF[3]);

        // Tests 3 and 5: two blocks back to back with flush probes.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'(i + 1), (i == 2 || i == 5) ? 1'b1 : 1'b0);
            if (i < 4) expect_out("t3_fill", 1'b0, 32'd0);
            else       expect_out("t3_sum", 1'b1, EXP_SUM[i-4]);
        end
        step(1'b1, 32'd0, 1'b1);    // flush with in_valid at the FEED boundary
        expect_out("t5_feed_z0", 1'b1, EXP_DIFF[0]);
        check("t5_feed_ready", {31'd0, in_ready}, 32'd1);
        step(1'b0, 32'd0, 1'b1);    // flush mid-FEED with cnt != 0
        expect_out("t5_idle", 1'b0, 32'd0);
        check("t5_idle_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            step(1'b1, 32'd0, 1'b0);
            if (i < 4) expect_out("t3_feed", 1'b1, EXP_DIFF[i]);
            else       expect_out("t3_sum0", 1'b1, 32'd0);
        end
        flush_drain("t3", 32'd0, 32'd0, 32'd0, 32'd0);

        // Test 4: in_valid toggled across the block.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'(i + 1), 1'b0);
            if (i < 4) expect_out("t4_fill", 1'b0, 32'd0);
            else       expect_out("t4_sum", 1'b1, EXP_SUM[i-4]);
            step(1'b0, 32'd0, 1'b0);
            expect_out("t4_idle", 1'b0, 32'd0);
        end
        flush_drain("t4", EXP_DIFF[0], EXP_DIFF[1], EXP_DIFF[2], EXP_DIFF[3]);

        // Test 6: near-modulus operands exercise the sum wrap (and halving).
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'd7680, 1'b0);
            if (i < 4) expect_out("t6_fill", 1'b0, 32'd0);
            else       expect_out("t6_sum", 1'b1, EXP_BIG);
        end
        flush_drain("t6", 32'd0, 32'd0, 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
